// File: rtl/imm_gen_unit_pkg.sv
// Shared types and constants for the VCPU-32 immediate generator.
// Field positions use the instruction's MSB-first (bit 0 = MSB) numbering.
package imm_gen_unit_pkg;

    localparam int WORD_LENGTH = 32;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_LDI   = 6'h01;
    localparam logic [5:0] OP_ADDIL = 6'h02;
    localparam logic [5:0] OP_ALUI  = 6'h03;
    localparam logic [5:0] OP_MEM   = 6'h04;
    localparam logic [5:0] OP_BR    = 6'h05;
    localparam logic [5:0] OP_SHF   = 6'h06;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_U22,
        FMT_L22,
        FMT_S18,
        FMT_S12,
        FMT_S19,
        FMT_U5
    } imm_fmt_t;

    localparam int OPC_MSB = 0;
    localparam int OPC_LSB = 5;
    localparam int U22_MSB = 10;
    localparam int S19_MSB = 13;
    localparam int S18_MSB = 14;
    localparam int S12_MSB = 20;
    localparam int U5_MSB  = 27;
    localparam int FLD_LSB = 31;

    localparam int L22_SHAMT = 10;
    localparam int S19_SHAMT = 2;

    function automatic imm_fmt_t decode_fmt(input logic [5:0] op);
        imm_fmt_t f;
        f = FMT_NONE;
        unique case (1'b1)
            (op == OP_LDI):   f = FMT_U22;
            (op == OP_ADDIL): f = FMT_L22;
            (op == OP_ALUI):  f = FMT_S18;
            (op == OP_MEM):   f = FMT_S12;
            (op == OP_BR):    f = FMT_S19;
            (op == OP_SHF):   f = FMT_U5;
            default:          f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_gen_unit_if.sv
// Decode-side bus of the immediate generator: advance, instruction in,
// registered immediate and valid flag out.
interface imm_gen_unit_if;
    import imm_gen_unit_pkg::*;

    logic                   en;
    logic [0:WORD_LENGTH-1] instr;
    logic [0:WORD_LENGTH-1] y;
    logic                   y_vld;

    modport master (
        output en,
        output instr,
        input  y,
        input  y_vld
    );

    modport slave (
        input  en,
        input  instr,
        output y,
        output y_vld
    );

endinterface

// File: rtl/imm_gen_unit_sign_ext.sv
// Extends a W-bit signed immediate field to a full word, either as plain
// two's complement or with the sign carried in the field LSB (low-sign).
module imm_sign_ext
    import imm_gen_unit_pkg::*;
#(
    parameter int W        = 12,
    parameter bit LOW_SIGN = 1'b0
) (
    input  logic [W-1:0]           field_i,
    output logic [WORD_LENGTH-1:0] value_o
);

    logic [W-1:0] tc_w;

    // Low-sign value mag - sign*2^(W-1) is simply {sign, mag} in two's complement.
    generate
        if (LOW_SIGN) begin : g_low
            assign tc_w = {field_i[0], field_i[W-1:1]};
        end else begin : g_tc
            assign tc_w = field_i;
        end
    endgenerate

    assign value_o = {{(WORD_LENGTH-W){tc_w[W-1]}}, tc_w};

endmodule

// File: rtl/imm_gen_unit.sv
// VCPU-32 immediate generator: opcode decode, field extract, registered result.
// Define IMMGEN_LOW_SIGN_EN to use low-sign encoding for S18/S12/S19.
module imm_gen_unit
    import imm_gen_unit_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    imm_gen_unit_if.slave bus
);

`ifdef IMMGEN_LOW_SIGN_EN
    localparam bit LowSign = 1'b1;
`else
    localparam bit LowSign = 1'b0;
`endif

    imm_fmt_t               fmt;
    logic [0:WORD_LENGTH-1] s18_w;
    logic [0:WORD_LENGTH-1] s12_w;
    logic [0:WORD_LENGTH-1] s19_w;
    logic [0:WORD_LENGTH-1] y_d;
    logic [0:WORD_LENGTH-1] y_q;
    logic                   vld_d;
    logic                   vld_q;
    logic                   unused_bits;

    assign fmt = decode_fmt(bus.instr[OPC_MSB:OPC_LSB]);
    assign unused_bits = ^bus.instr[OPC_LSB+1:U22_MSB-1];

    imm_sign_ext #(
        .W        (FLD_LSB-S18_MSB+1),
        .LOW_SIGN (LowSign)
    ) u_s18 (
        .field_i (bus.instr[S18_MSB:FLD_LSB]),
        .value_o (s18_w)
    );

    imm_sign_ext #(
        .W        (FLD_LSB-S12_MSB+1),
        .LOW_SIGN (LowSign)
    ) u_s12 (
        .field_i (bus.instr[S12_MSB:FLD_LSB]),
        .value_o (s12_w)
    );

    imm_sign_ext #(
        .W        (FLD_LSB-S19_MSB+1),
        .LOW_SIGN (LowSign)
    ) u_s19 (
        .field_i (bus.instr[S19_MSB:FLD_LSB]),
        .value_o (s19_w)
    );

    always_comb begin
        y_d   = '0;
        vld_d = 1'b1;
        unique case (fmt)
            FMT_U22: y_d = {{U22_MSB{1'b0}},
                            bus.instr[U22_MSB:FLD_LSB]};
            FMT_L22: y_d = {bus.instr[U22_MSB:FLD_LSB],
                            {L22_SHAMT{1'b0}}};
            FMT_S18: y_d = s18_w;
            FMT_S12: y_d = s12_w;
            FMT_S19: y_d = {s19_w[S19_SHAMT:WORD_LENGTH-1],
                            {S19_SHAMT{1'b0}}};
            FMT_U5:  y_d = {{U5_MSB{1'b0}},
                            bus.instr[U5_MSB:FLD_LSB]};
            default: vld_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else if (bus.en) begin
            y_q   <= y_d;
            vld_q <= vld_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.y_vld = vld_q;

endmodule

// File: tb/tb_imm_gen_unit.sv
// Self-checking bench for imm_gen_unit: vector table, reset/stall
// sequences and randomized instructions against an arithmetic model.
module tb_imm_gen_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    imm_gen_unit_if bus();

    imm_gen_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] y;
        logic        vld;
    } vec_t;

    vec_t vecs[$];

    function automatic longint sfield(input longint f, input int w);
        longint half;
        half = longint'(1) << (w - 1);
`ifdef IMMGEN_LOW_SIGN_EN
        return (f >> 1) - (((f & 1) != 0) ? half : 0);
`else
        return (f >= half) ? f - 2 * half : f;
`endif
    endfunction

    // Returns {vld, y} computed from the format rules.
    function automatic logic [32:0] model(input logic [31:0] ins);
        longint      v;
        logic [63:0] t;
        int unsigned op;
        op = ins >> 26;
        v  = 0;
        case (op)
            1: v = ins & 32'h003FFFFF;
            2: v = (ins & 32'h003FFFFF) * 1024;
            3: v = sfield(ins & 32'h0003FFFF, 18);
            4: v = sfield(ins & 32'h00000FFF, 12);
            5: v = sfield(ins & 32'h0007FFFF, 19) * 4;
            6: v = ins & 32'h1F;
            default: return 33'h0;
        endcase
        t = v;
        return {1'b1, t[31:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] ey,
                         input logic ev);
        checks++;
        if (bus.y !== ey || bus.y_vld !== ev) begin
            failures++;
            $display("FAIL %s: y=%h vld=%b expected y=%h vld=%b",
                     name, bus.y, bus.y_vld, ey, ev);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic e);
        bus.instr = ins;
        bus.en    = e;
    endtask

    logic [31:0] exp_y;
    logic        exp_v;
    logic [31:0] rin;
    logic [32:0] m;
    logic        ren;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(32'h0, 1'b0);
        #1;
        check("reset_init", 32'h0, 1'b0);

        vecs.push_back('{32'h043FFFFF, 32'h003FFFFF, 1'b1});
        vecs.push_back('{32'h08000001, 32'h00000400, 1'b1});
        vecs.push_back('{32'h18FFFFF3, 32'h00000013, 1'b1});
        vecs.push_back('{32'hFC123456, 32'h00000000, 1'b0});
        vecs.push_back('{32'h00ABCDEF, 32'h00000000, 1'b0});
        vecs.push_back('{32'h1C000005, 32'h00000000, 1'b0});
        vecs.push_back('{32'h0BFFFFFF, 32'hFFFFFC00, 1'b1});
`ifdef IMMGEN_LOW_SIGN_EN
        vecs.push_back('{32'h10000001, 32'hFFFFF800, 1'b1});
        vecs.push_back('{32'h10000002, 32'h00000001, 1'b1});
        vecs.push_back('{32'h14000001, 32'hFFF00000, 1'b1});
        vecs.push_back('{32'h10000800, 32'h00000400, 1'b1});
        vecs.push_back('{32'h0C020000, 32'h00010000, 1'b1});
        vecs.push_back('{32'h0C03FFFF, 32'hFFFFFFFF, 1'b1});
`else
        vecs.push_back('{32'h0C03FFFF, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{32'h10000800, 32'hFFFFF800, 1'b1});
        vecs.push_back('{32'h1407FFFF, 32'hFFFFFFFC, 1'b1});
        vecs.push_back('{32'h1000007F, 32'h0000007F, 1'b1});
        vecs.push_back('{32'h0C020000, 32'hFFFE0000, 1'b1});
        vecs.push_back('{32'h14040000, 32'hFFF00000, 1'b1});
`endif

        step();
        step();
        check("reset_hold", 32'h0, 1'b0);
        rst_n = 1'b1;
        step();
        check("reset_release", 32'h0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].instr, 1'b1);
            step();
            check($sformatf("vec%0d_%h", i, vecs[i].instr),
                  vecs[i].y, vecs[i].vld);
        end

        // Stall: output holds while en is low, then follows one cycle later.
        drive(32'h043FFFFF, 1'b1);
        step();
        check("stall_load", 32'h003FFFFF, 1'b1);
        drive(32'h10000800, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall_hold%0d", k), 32'h003FFFFF, 1'b1);
        end
        bus.en = 1'b1;
        step();
`ifdef IMMGEN_LOW_SIGN_EN
        check("stall_resume", 32'h00000400, 1'b1);
`else
        check("stall_resume", 32'hFFFFF800, 1'b1);
`endif

        // Asynchronous reset mid-run, between clock edges.
        drive(32'h043FFFFF, 1'b1);
        step();
        check("pre_reset", 32'h003FFFFF, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", 32'h0, 1'b0);
        drive(32'h043FFFFF, 1'b1);
        step();
        check("reset_dominates_en", 32'h0, 1'b0);
        drive(32'h0, 1'b1);
        rst_n = 1'b1;
        step();
        check("reset_nop", 32'h0, 1'b0);

        exp_y = 32'h0;
        exp_v = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rin = $urandom;
            if ($urandom_range(0, 9) < 8)
                rin[31:26] = 6'($urandom_range(0, 7));
            ren = ($urandom_range(0, 3) != 0);
            drive(rin, ren);
            if (ren) begin
                m     = model(rin);
                exp_y = m[31:0];
                exp_v = m[32];
            end
            step();
            check($sformatf("rand%0d_%h_en%0b", n, rin, ren), exp_y, exp_v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
